vga_timing_gen: RTL and testbench

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_timing_gen.sv | 107 ++++++++++
 tb/tb_vga_timing_gen.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: free-running h/v counters decoded into registered
// sync, blanking and pixel coordinates, plus frame and divided game strobes.
`ifndef PIXEL_DISPLAY_BIT
`define PIXEL_DISPLAY_BIT 9
`endif

module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic                        clock_25,
  input  logic                        reset,
  input  logic [3:0]                  speed_div,
  output logic [`PIXEL_DISPLAY_BIT:0] X,
  output logic [`PIXEL_DISPLAY_BIT:0] Y,
  output logic                        display_enable,
  output logic                        hsync,
  output logic                        vsync,
  output logic                        frame_tick,
  output logic                        game_tick
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int PW      = `PIXEL_DISPLAY_BIT + 1;

  localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_VIS_END  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SYNC_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SYNC_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_VIS_END  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SYNC_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SYNC_END = VW'(V_ACTIVE + V_FP + V_SYNC);

  logic [HW-1:0] r_h_count;
  logic [VW-1:0] r_v_count;
  logic [3:0]    r_frame_cnt;

  logic       w_h_last;
  logic       w_v_last;
  logic       w_frame;
  logic       w_de;
  logic       w_hsync_n;
  logic       w_vsync_n;
  logic [4:0] w_eff;
  logic       w_game;

  assign w_h_last  = (r_h_count == H_LAST);
  assign w_v_last  = (r_v_count == V_LAST);
  assign w_frame   = w_h_last && w_v_last;
  assign w_de      = (r_h_count < H_VIS_END) && (r_v_count < V_VIS_END);
  assign w_hsync_n = !((r_h_count >= H_SYNC_BEG) && (r_h_count < H_SYNC_END));
  assign w_vsync_n = !((r_v_count >= V_SYNC_BEG) && (r_v_count < V_SYNC_END));

  // A divider of 0 behaves as 1; ">=" (not "==") lets a lowered divider fire at once
  assign w_eff  = (speed_div == 4'd0) ? 5'd1 : {1'b0, speed_div};
  assign w_game = w_frame && ({1'b0, r_frame_cnt} >= (w_eff - 5'd1));

  always_ff @(posedge clock_25 or posedge reset) begin
    if (reset) begin
      r_h_count   <= '0;
      r_v_count   <= '0;
      r_frame_cnt <= '0;
    end else begin
      if (w_h_last) begin
        r_h_count <= '0;
        r_v_count <= w_v_last ? '0 : r_v_count + VW'(1);
      end else begin
        r_h_count <= r_h_count + HW'(1);
      end
      if (w_frame) begin
        r_frame_cnt <= w_game ? 4'd0 : r_frame_cnt + 4'd1;
      end
    end
  end

  // Output stage: everything below is the decode of the current counter state
  always_ff @(posedge clock_25 or posedge reset) begin
    if (reset) begin
      X              <= '0;
      Y              <= '0;
      display_enable <= 1'b0;
      hsync          <= 1'b1;
      vsync          <= 1'b1;
      frame_tick     <= 1'b0;
      game_tick      <= 1'b0;
    end else begin
      X              <= w_de ? PW'(r_h_count) : '0;
      Y              <= w_de ? PW'(r_v_count) : '0;
      display_enable <= w_de;
      hsync          <= w_hsync_n;
      vsync          <= w_vsync_n;
      frame_tick     <= w_frame;
      game_tick      <= w_game;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomized bench for vga_timing_gen on a shrunken raster, checked against a
// model that derives every output from the clock index since reset release.
module tb_vga_timing_gen;

  localparam int HA = 16, HF = 2, HS = 4, HB = 3;
  localparam int VA = 10, VF = 2, VS = 2, VB = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] sd  = 4'd0;
  logic [9:0] X, Y;
  logic       display_enable, hsync, vsync, frame_tick, game_tick;

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut (
    .clock_25(clk), .reset(rst), .speed_div(sd),
    .X(X), .Y(Y), .display_enable(display_enable),
    .hsync(hsync), .vsync(vsync),
    .frame_tick(frame_tick), .game_tick(game_tick)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int k  = 0;   // clocks since reset release
  int fs = 0;   // frames since last game tick

  int win, de_cnt, hs_cnt, vs_cnt, ft_cnt, gt_cnt, first_hs, xmax, ymax, gt_mask;

  task automatic chk(input string tag, input int obs, input int exp);
    vectors++;
    if (obs != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic clear_tally();
    win = 0; de_cnt = 0; hs_cnt = 0; vs_cnt = 0; ft_cnt = 0; gt_cnt = 0;
    first_hs = -1; xmax = 0; ymax = 0; gt_mask = 0;
  endtask

  task automatic check_reset_vals();
    chk("rst_X", int'(X), 0);
    chk("rst_Y", int'(Y), 0);
    chk("rst_de", int'(display_enable), 0);
    chk("rst_hsync", int'(hsync), 1);
    chk("rst_vsync", int'(vsync), 1);
    chk("rst_frame_tick", int'(frame_tick), 0);
    chk("rst_game_tick", int'(game_tick), 0);
  endtask

  task automatic tick();
    logic [3:0] sd_s;
    int n, h, v, eff;
    bit ede, eft, egt;
    sd_s = sd;
    @(posedge clk);
    #1;
    if (rst) begin
      k = 0;
      fs = 0;
      check_reset_vals();
    end else begin
      k++;
      n = (k - 1) % FRAME;
      h = n % HT;
      v = n / HT;
      ede = (h < HA) && (v < VA);
      eft = (n == FRAME - 1);
      egt = 1'b0;
      if (eft) begin
        fs++;
        eff = (sd_s == 4'd0) ? 1 : int'(sd_s);
        if (fs >= eff) begin
          egt = 1'b1;
          fs = 0;
        end
      end
      chk("de", int'(display_enable), int'(ede));
      chk("X", int'(X), ede ? h : 0);
      chk("Y", int'(Y), ede ? v : 0);
      chk("hsync", int'(hsync), (h >= HA + HF && h < HA + HF + HS) ? 0 : 1);
      chk("vsync", int'(vsync), (v >= VA + VF && v < VA + VF + VS) ? 0 : 1);
      chk("frame_tick", int'(frame_tick), int'(eft));
      chk("game_tick", int'(game_tick), int'(egt));
      chk("xy_blank", int'(!display_enable && (X != 0 || Y != 0)), 0);
    end
    chk("gt_without_ft", int'(game_tick && !frame_tick), 0);
    win++;
    if (display_enable) de_cnt++;
    if (!hsync) begin
      hs_cnt++;
      if (first_hs < 0) first_hs = win;
    end
    if (!vsync) vs_cnt++;
    if (int'(X) > xmax) xmax = int'(X);
    if (int'(Y) > ymax) ymax = int'(Y);
    if (frame_tick) begin
      ft_cnt++;
      if (game_tick && ft_cnt < 31) gt_mask |= (1 << ft_cnt);
    end
    if (game_tick) gt_cnt++;
  endtask

  task automatic async_reset();
    #2;
    rst = 1'b1;
    #1;
    k = 0;
    fs = 0;
    check_reset_vals();
  endtask

  task automatic wait_frame_from_release();
    int c;
    c = 0;
    do begin
      tick();
      c++;
    end while (!frame_tick && c < 2 * FRAME);
    chk("ft_latency", c, FRAME);
  endtask

  initial begin
    clear_tally();
    #1 rst = 1'b1;
    #1 check_reset_vals();
    repeat (3) tick();
    rst = 1'b0;

    // First line, then the rest of the first frame
    clear_tally();
    repeat (HT) tick();
    chk("line_de_cnt", de_cnt, HA);
    chk("line_hs_cnt", hs_cnt, HS);
    chk("line_hs_first", first_hs, HA + HF + 1);
    chk("line_xmax", xmax, HA - 1);
    repeat (FRAME - HT) tick();
    chk("frame_ft_cnt", ft_cnt, 1);
    chk("frame_vs_cnt", vs_cnt, VS * HT);
    chk("frame_ymax", ymax, VA - 1);
    chk("frame_de_cnt", de_cnt, HA * VA);

    // Divide by 3 over 9 frames
    sd = 4'd3;
    clear_tally();
    repeat (9 * FRAME) tick();
    chk("div3_ft_cnt", ft_cnt, 9);
    chk("div3_gt_mask", gt_mask, (1 << 3) | (1 << 6) | (1 << 9));

    // Divider of zero acts as one
    sd = 4'd0;
    clear_tally();
    repeat (3 * FRAME) tick();
    chk("div0_gt_cnt", gt_cnt, 3);

    // 15 for ten frames, then lowered to 2
    sd = 4'd15;
    clear_tally();
    repeat (10 * FRAME) tick();
    chk("div15_gt_cnt", gt_cnt, 0);
    sd = 4'd2;
    clear_tally();
    repeat (5 * FRAME) tick();
    chk("div2_gt_mask", gt_mask, (1 << 1) | (1 << 3) | (1 << 5));

    // Reset in the middle of a frame
    begin
      int c;
      c = 0;
      while (((k - 1) % FRAME) != 5 * HT + 7 && c < 2 * FRAME) begin
        tick();
        c++;
      end
      chk("mid_reached", int'(((k - 1) % FRAME) == 5 * HT + 7), 1);
    end
    async_reset();
    repeat (2) tick();
    rst = 1'b0;
    wait_frame_from_release();

    // Random divider changes and reset pulses
    repeat (40) begin
      if ($urandom_range(0, 3) == 0) sd = 4'($urandom_range(0, 15));
      repeat ($urandom_range(1, 2 * FRAME)) tick();
      if ($urandom_range(0, 5) == 0) begin
        async_reset();
        repeat ($urandom_range(0, 3)) tick();
        rst = 1'b0;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
